// File: rtl/wbs_desc_mem_if.sv
// Wishbone 64-bit descriptor port bundle (dual 32-bit data lanes).
// The master drives the *_i signals and the slave drives the *_o signals.
interface wbs_desc_mem_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic        wbs_cab_i;
    logic        wbs_pref_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat64_i;
    logic [31:0] wbs_dat_o;
    logic [31:0] wbs_dat64_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic        wbs_rty_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_cab_i, wbs_pref_i,
        input  wbs_sel_i, wbs_adr_i, wbs_dat_i, wbs_dat64_i,
        output wbs_dat_o, wbs_dat64_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_cab_i, wbs_pref_i,
        output wbs_sel_i, wbs_adr_i, wbs_dat_i, wbs_dat64_i,
        input  wbs_dat_o, wbs_dat64_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );
endinterface

// File: rtl/wbs_desc_mem.sv
// wbs_desc_mem: Wishbone 64-bit descriptor memory slave with host backdoor.
// Define WBS_DESC_MEM_ERR_EN to answer out-of-range beats with err instead of aliasing.
module wbs_desc_mem #(
    parameter int          AW       = 6,
    parameter logic [31:0] BASE_ADR = 32'h0000_0000,
    parameter int          WAIT_CYC = 0
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    wbs_desc_mem_if.slave wbs,
    input  logic          hst_we,
    input  logic [AW-1:0] hst_adr,
    input  logic [63:0]   hst_dat,
    output logic [63:0]   hst_q,
    output logic          hst_drop,
    output logic [15:0]   beat_cnt
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          oob_q, oob_d;
    logic [63:0]   dat_q;
    logic [63:0]   hst_q_q;
    logic          hst_drop_q;
    logic [15:0]   beat_cnt_q;
    logic [63:0]   mem [DEPTH];

    logic [28:0]   idx;
    logic          cs, ack_eff, err_eff;
    logic          wr_en, hst_ok;
    logic          lat_oob, wrap_oob;
    logic          unused_bus;

    assign cs      = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign ack_eff = ack_q & cs;
    assign err_eff = err_q & cs;
    assign idx     = wbs.wbs_adr_i[31:3] - BASE_ADR[31:3];
    assign wr_en   = ack_eff & wbs.wbs_we_i;
    assign hst_ok  = hst_we & (state_q == S_IDLE) & ~wbs.wbs_cyc_i;

    assign unused_bus = ^{wbs.wbs_pref_i, wbs.wbs_adr_i[2:0]};

`ifdef WBS_DESC_MEM_ERR_EN
    assign lat_oob  = |idx[28:AW];
    assign wrap_oob = (ptr_q == {AW{1'b1}});
`else
    logic unused_idx;
    assign lat_oob    = 1'b0;
    assign wrap_oob   = 1'b0;
    assign unused_idx = ^idx[28:AW];
`endif

    assign wbs.wbs_ack_o   = ack_eff;
    assign wbs.wbs_err_o   = err_eff;
    assign wbs.wbs_rty_o   = 1'b0;
    assign wbs.wbs_dat_o   = dat_q[31:0];
    assign wbs.wbs_dat64_o = dat_q[63:32];
    assign hst_q           = hst_q_q;
    assign hst_drop        = hst_drop_q;
    assign beat_cnt        = beat_cnt_q;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        ptr_d   = ptr_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        oob_d   = oob_q;
        unique case (state_q)
            S_IDLE, S_GAP: begin
                if (cs) begin
                    ptr_d = idx[AW-1:0];
                    oob_d = lat_oob;
                    if (WAIT_CYC > 0) begin
                        state_d = S_WAIT;
                        wcnt_d  = 4'(WAIT_CYC);
                    end else begin
                        state_d = S_BEAT;
                        ack_d   = ~lat_oob;
                        err_d   = lat_oob;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!wbs.wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (wcnt_q == 4'd1) begin
                    state_d = S_BEAT;
                    ack_d   = ~oob_q;
                    err_d   = oob_q;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_BEAT: begin
                if (!wbs.wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (err_eff) begin
                    state_d = S_GAP;
                end else if (ack_eff) begin
                    ptr_d = ptr_q + 1'b1;
                    if (wbs.wbs_cab_i) begin
                        // the beat after the top word becomes an err beat
                        ack_d = ~wrap_oob;
                        err_d = wrap_oob;
                        oob_d = wrap_oob;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    ack_d = ack_q;
                    err_d = err_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            ptr_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            oob_q      <= 1'b0;
            dat_q      <= '0;
            hst_q_q    <= '0;
            hst_drop_q <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            oob_q      <= oob_d;
            dat_q      <= mem[ptr_d];
            hst_q_q    <= mem[hst_adr];
            hst_drop_q <= hst_we & ~hst_ok;
            if (ack_eff) beat_cnt_q <= beat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wbs.wbs_sel_i[i]) begin
                    mem[ptr_q][8*i +: 8]    <= wbs.wbs_dat_i[8*i +: 8];
                    mem[ptr_q][32+8*i +: 8] <= wbs.wbs_dat64_i[8*i +: 8];
                end
            end
        end
        if (hst_ok) mem[hst_adr] <= hst_dat;
    end
endmodule

// File: tb/tb_wbs_desc_mem.sv
// Bench for wbs_desc_mem: directed scenarios plus random bursts
// checked against a word-array model of host memory.
module tb_wbs_desc_mem;
    localparam int AW = 6;
    localparam int N  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        m_cyc = 0, m_stb = 0, m_we = 0, m_cab = 0, m_pref = 0;
    logic [3:0]  m_sel = 0;
    logic [31:0] m_adr = 0, m_dlo = 0, m_dhi = 0;
    logic        use3 = 0;
    logic          hst_we = 0;
    logic [AW-1:0] hst_adr = 0;
    logic [63:0]   hst_dat = 0;
    logic [63:0] hst_q, hst_q3;
    logic        hst_drop, hst_drop3;
    logic [15:0] beat_cnt, beat_cnt3;

    wbs_desc_mem_if if0 ();
    wbs_desc_mem_if if3 ();

    assign if0.wbs_cyc_i   = m_cyc & ~use3;
    assign if0.wbs_stb_i   = m_stb & ~use3;
    assign if0.wbs_we_i    = m_we;
    assign if0.wbs_cab_i   = m_cab;
    assign if0.wbs_pref_i  = m_pref;
    assign if0.wbs_sel_i   = m_sel;
    assign if0.wbs_adr_i   = m_adr;
    assign if0.wbs_dat_i   = m_dlo;
    assign if0.wbs_dat64_i = m_dhi;
    assign if3.wbs_cyc_i   = m_cyc & use3;
    assign if3.wbs_stb_i   = m_stb & use3;
    assign if3.wbs_we_i    = m_we;
    assign if3.wbs_cab_i   = m_cab;
    assign if3.wbs_pref_i  = m_pref;
    assign if3.wbs_sel_i   = m_sel;
    assign if3.wbs_adr_i   = m_adr;
    assign if3.wbs_dat_i   = m_dlo;
    assign if3.wbs_dat64_i = m_dhi;

    logic        s_ack, s_err;
    logic [63:0] s_dat;
    assign s_ack = use3 ? if3.wbs_ack_o : if0.wbs_ack_o;
    assign s_err = use3 ? if3.wbs_err_o : if0.wbs_err_o;
    assign s_dat = use3 ? {if3.wbs_dat64_o, if3.wbs_dat_o}
                        : {if0.wbs_dat64_o, if0.wbs_dat_o};

    wbs_desc_mem #(.AW(AW), .BASE_ADR(32'h0), .WAIT_CYC(0)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs(if0.slave),
        .hst_we(hst_we), .hst_adr(hst_adr), .hst_dat(hst_dat),
        .hst_q(hst_q), .hst_drop(hst_drop), .beat_cnt(beat_cnt));

    wbs_desc_mem #(.AW(AW), .BASE_ADR(32'h0), .WAIT_CYC(3)) dut3 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs(if3.slave),
        .hst_we(1'b0), .hst_adr('0), .hst_dat('0),
        .hst_q(hst_q3), .hst_drop(hst_drop3), .beat_cnt(beat_cnt3));

    int checks = 0, errors = 0;
    int exp_beats = 0;
    logic [63:0] model [N];
    logic [63:0] wbuf [16];
    logic [63:0] rbuf [16];
    int          ackc [16];
    logic        errf [16];
    logic        ackf [16];
    int          got;
    logic        late;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [3:0] sel);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++)
            if (sel[b % 4]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic hst_write(input int idx, input logic [63:0] d);
        @(posedge clk); #1;
        hst_we = 1; hst_adr = AW'(idx); hst_dat = d;
        @(posedge clk); #1;
        hst_we = 0;
        model[idx] = d;
    endtask

    task automatic hst_read(input int idx, output logic [63:0] q);
        @(posedge clk); #1;
        hst_adr = AW'(idx);
        @(posedge clk); #1;
        q = hst_q;
    endtask

    task automatic do_burst(input int idx, input int n, input logic we,
                            input logic cab, input logic [3:0] sel);
        int   cc;
        logic hit;
        got = 0;
        cc  = 0;
        @(posedge clk); #1;
        m_cyc = 1; m_stb = 1; m_we = we; m_cab = cab; m_sel = sel;
        m_pref = 1'($urandom);
        m_adr = 32'(idx * 8) + 32'($urandom_range(0, 7));
        {m_dhi, m_dlo} = wbuf[0];
        while (got < n && cc < 64) begin
            @(negedge clk);
            cc++;
            hit = s_ack | s_err;
            if (hit) begin
                rbuf[got] = s_dat;
                ackc[got] = cc;
                ackf[got] = s_ack;
                errf[got] = s_err;
                got++;
            end
            @(posedge clk); #1;
            if (hit && got < n) begin
                m_adr = m_adr + 32'd8;
                {m_dhi, m_dlo} = wbuf[got];
            end
        end
        m_cyc = 0; m_stb = 0; m_we = 0; m_cab = 0;
        @(negedge clk);
        late = s_ack | s_err;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (if0.wbs_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", if0.wbs_ack_o); end
        checks++; if (if0.wbs_err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", if0.wbs_err_o); end
        checks++; if (if0.wbs_rty_o !== 1'b0) begin errors++; $display("FAIL rst_rty got %b exp 0", if0.wbs_rty_o); end
        checks++; if (s_dat !== 64'h0) begin errors++; $display("FAIL rst_dat got %h exp 0", s_dat); end
        checks++; if (hst_q !== 64'h0) begin errors++; $display("FAIL rst_hst_q got %h exp 0", hst_q); end
        checks++; if (hst_drop !== 1'b0) begin errors++; $display("FAIL rst_drop got %b exp 0", hst_drop); end
        checks++; if (beat_cnt !== 16'h0) begin errors++; $display("FAIL rst_beats got %h exp 0", beat_cnt); end
        @(negedge clk);
        rst = 0;
        exp_beats = 0;
        for (int i = 0; i < N; i++) hst_write(i, {$urandom, $urandom});
    endtask

    task automatic test_read_burst;
        for (int i = 4; i < 8; i++) hst_write(i, 64'h1111_0000_0000_0010 + 64'(i));
        do_burst(4, 4, 1'b0, 1'b1, 4'hF);
        checks++; if (got !== 4) begin errors++; $display("FAIL rd_count got %0d exp 4", got); end
        for (int k = 0; k < got; k++) begin
            checks++;
            if (rbuf[k] !== 64'h1111_0000_0000_0014 + 64'(k)) begin
                errors++; $display("FAIL rd_data%0d got %h exp %h", k, rbuf[k], 64'h1111_0000_0000_0014 + 64'(k));
            end
            if (k > 0) begin
                checks++;
                if (ackc[k] - ackc[k-1] != 1) begin errors++; $display("FAIL rd_spacing%0d got %0d exp 1", k, ackc[k] - ackc[k-1]); end
            end
        end
        exp_beats += got;
        checks++; if (beat_cnt !== 16'(exp_beats)) begin errors++; $display("FAIL rd_beats got %0d exp %0d", beat_cnt, exp_beats); end
        checks++; if (late !== 1'b0) begin errors++; $display("FAIL rd_extra_ack got %b exp 0", late); end
    endtask

    task automatic test_write_burst;
        logic [63:0] pre8, pre9, q;
        pre8 = model[8];
        pre9 = model[9];
        wbuf[0] = 64'h1122_3344_AABB_CCDD;
        wbuf[1] = 64'h1122_3344_AABB_CCDD;
        do_burst(8, 2, 1'b1, 1'b1, 4'b0011);
        exp_beats += got;
        model[8] = merge(model[8], wbuf[0], 4'b0011);
        model[9] = merge(model[9], wbuf[1], 4'b0011);
        hst_read(8, q);
        checks++;
        if (q !== {pre8[63:48], 16'h3344, pre8[31:16], 16'hCCDD}) begin
            errors++; $display("FAIL wr_sel8 got %h exp %h", q, {pre8[63:48], 16'h3344, pre8[31:16], 16'hCCDD});
        end
        hst_read(9, q);
        checks++;
        if (q !== {pre9[63:48], 16'h3344, pre9[31:16], 16'hCCDD}) begin
            errors++; $display("FAIL wr_sel9 got %h exp %h", q, {pre9[63:48], 16'h3344, pre9[31:16], 16'hCCDD});
        end
        wbuf[0] = {$urandom, $urandom};
        do_burst(9, 1, 1'b1, 1'b0, 4'b0000);
        exp_beats += got;
        checks++; if (got !== 1) begin errors++; $display("FAIL wr_sel0_ack got %0d exp 1", got); end
        hst_read(9, q);
        checks++; if (q !== model[9]) begin errors++; $display("FAIL wr_sel0_keep got %h exp %h", q, model[9]); end
        checks++; if (beat_cnt !== 16'(exp_beats)) begin errors++; $display("FAIL wr_beats got %0d exp %0d", beat_cnt, exp_beats); end
    endtask

    task automatic test_wait_states;
        @(posedge clk); #1;
        use3 = 1;
        do_burst(4, 3, 1'b0, 1'b1, 4'hF);
        checks++; if (got !== 3) begin errors++; $display("FAIL wait_count got %0d exp 3", got); end
        checks++; if (ackc[0] - 1 != 4) begin errors++; $display("FAIL wait_first got %0d exp 4", ackc[0] - 1); end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (ackc[k] - ackc[k-1] != 1) begin errors++; $display("FAIL wait_spacing%0d got %0d exp 1", k, ackc[k] - ackc[k-1]); end
        end
        checks++; if (beat_cnt3 !== 16'd3) begin errors++; $display("FAIL wait_beats got %0d exp 3", beat_cnt3); end
        @(posedge clk); #1;
        use3 = 0;
    endtask

    task automatic test_single;
        do_burst(0, 2, 1'b0, 1'b0, 4'hF);
        exp_beats += got;
        checks++; if (got !== 2) begin errors++; $display("FAIL single_count got %0d exp 2", got); end
        checks++; if (rbuf[0] !== model[0]) begin errors++; $display("FAIL single_d0 got %h exp %h", rbuf[0], model[0]); end
        checks++; if (rbuf[1] !== model[1]) begin errors++; $display("FAIL single_d1 got %h exp %h", rbuf[1], model[1]); end
        checks++; if (ackc[1] - ackc[0] < 2) begin errors++; $display("FAIL single_gap got %0d exp >=2", ackc[1] - ackc[0]); end
    endtask

    task automatic test_hst_drop;
        logic [63:0] q;
        @(posedge clk); #1;
        m_cyc = 1;
        hst_we = 1; hst_adr = 6'd30; hst_dat = ~model[30];
        @(posedge clk); #1;
        hst_we = 0;
        checks++; if (hst_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b exp 1", hst_drop); end
        @(posedge clk); #1;
        checks++; if (hst_drop !== 1'b0) begin errors++; $display("FAIL drop_width got %b exp 0", hst_drop); end
        m_cyc = 0;
        hst_read(30, q);
        checks++; if (q !== model[30]) begin errors++; $display("FAIL drop_mem got %h exp %h", q, model[30]); end
        hst_write(31, {$urandom, $urandom});
        checks++; if (hst_drop !== 1'b0) begin errors++; $display("FAIL drop_ok got %b exp 0", hst_drop); end
    endtask

    task automatic test_reset_mid;
        int          cc;
        logic        hit;
        logic [63:0] q;
        for (int k = 0; k < 4; k++) wbuf[k] = {$urandom, $urandom};
        got = 0; cc = 0;
        @(posedge clk); #1;
        m_cyc = 1; m_stb = 1; m_we = 1; m_cab = 1; m_sel = 4'hF;
        m_adr = 32'(12 * 8);
        {m_dhi, m_dlo} = wbuf[0];
        while (got < 2 && cc < 64) begin
            @(negedge clk);
            cc++;
            hit = s_ack;
            if (hit) got++;
            @(posedge clk); #1;
            if (hit) {m_dhi, m_dlo} = wbuf[got];
        end
        checks++; if (got !== 2) begin errors++; $display("FAIL rm_prefix got %0d exp 2", got); end
        model[12] = wbuf[0];
        model[13] = wbuf[1];
        rst = 1; m_we = 0; m_adr = 32'(20 * 8);
        #1;
        checks++; if (s_ack !== 1'b0) begin errors++; $display("FAIL rm_ack got %b exp 0", s_ack); end
        checks++; if (beat_cnt !== 16'h0) begin errors++; $display("FAIL rm_beats got %0d exp 0", beat_cnt); end
        exp_beats = 0;
        @(negedge clk);
        rst = 0;
        cc = 0; hit = 0;
        while (!hit && cc < 64) begin
            @(negedge clk);
            cc++;
            hit = s_ack;
        end
        checks++; if (cc != 1) begin errors++; $display("FAIL rm_restart got %0d exp 1", cc); end
        checks++; if (s_dat !== model[20]) begin errors++; $display("FAIL rm_data got %h exp %h", s_dat, model[20]); end
        @(posedge clk); #1;
        m_cyc = 0; m_stb = 0; m_cab = 0;
        if (hit) exp_beats++;
        @(posedge clk); #1;
        checks++; if (beat_cnt !== 16'(exp_beats)) begin errors++; $display("FAIL rm_beats2 got %0d exp %0d", beat_cnt, exp_beats); end
        for (int i = 12; i < 15; i++) begin
            hst_read(i, q);
            checks++; if (q !== model[i]) begin errors++; $display("FAIL rm_mem%0d got %h exp %h", i, q, model[i]); end
        end
    endtask

    task automatic test_range;
        do_burst(64, 1, 1'b0, 1'b0, 4'hF);
        checks++; if (got !== 1) begin errors++; $display("FAIL range_resp got %0d exp 1", got); end
`ifdef WBS_DESC_MEM_ERR_EN
        checks++; if (errf[0] !== 1'b1) begin errors++; $display("FAIL range_err got %b exp 1", errf[0]); end
        checks++; if (ackf[0] !== 1'b0) begin errors++; $display("FAIL range_ack got %b exp 0", ackf[0]); end
`else
        checks++; if (errf[0] !== 1'b0) begin errors++; $display("FAIL range_err got %b exp 0", errf[0]); end
        checks++; if (rbuf[0] !== model[0]) begin errors++; $display("FAIL range_alias got %h exp %h", rbuf[0], model[0]); end
        exp_beats += got;
`endif
        checks++; if (beat_cnt !== 16'(exp_beats)) begin errors++; $display("FAIL range_beats got %0d exp %0d", beat_cnt, exp_beats); end
    endtask

    task automatic test_random;
        int          idx, len, j, sp;
        logic        we, cab;
        logic [3:0]  sel;
        logic [63:0] q;
        for (int it = 0; it < 24; it++) begin
            idx = $urandom_range(0, N - 1);
            len = $urandom_range(1, 5);
`ifdef WBS_DESC_MEM_ERR_EN
            if (idx > N - len) idx = N - len;
`endif
            we  = 1'($urandom);
            cab = 1'($urandom);
            sel = 4'($urandom);
            for (int k = 0; k < len; k++) wbuf[k] = {$urandom, $urandom};
            do_burst(idx, len, we, cab, sel);
            checks++; if (got !== len) begin errors++; $display("FAIL rnd%0d_count got %0d exp %0d", it, got, len); end
            checks++; if (late !== 1'b0) begin errors++; $display("FAIL rnd%0d_extra got %b exp 0", it, late); end
            sp = cab ? 1 : 2;
            for (int k = 0; k < got; k++) begin
                j = (idx + k) % N;
                if (we) begin
                    model[j] = merge(model[j], wbuf[k], sel);
                end else begin
                    checks++;
                    if (rbuf[k] !== model[j]) begin errors++; $display("FAIL rnd%0d_rd%0d got %h exp %h", it, k, rbuf[k], model[j]); end
                end
                if (k > 0) begin
                    checks++;
                    if (ackc[k] - ackc[k-1] != sp) begin errors++; $display("FAIL rnd%0d_sp%0d got %0d exp %0d", it, k, ackc[k] - ackc[k-1], sp); end
                end
            end
            exp_beats += got;
            checks++; if (beat_cnt !== 16'(exp_beats)) begin errors++; $display("FAIL rnd%0d_beats got %0d exp %0d", it, beat_cnt, exp_beats); end
            if (we) begin
                for (int k = 0; k < len; k++) begin
                    j = (idx + k) % N;
                    hst_read(j, q);
                    checks++; if (q !== model[j]) begin errors++; $display("FAIL rnd%0d_mem%0d got %h exp %h", it, j, q, model[j]); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_write_burst();
        test_wait_states();
        test_single();
        test_hst_drop();
        test_reset_mid();
        test_range();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
